// File: rtl/program_sequencer_pkg.sv
// Shared types and constants for the program launch sequencer.
// Holds the FSM state encoding, the program selector codes and the launch priority encoder.
package program_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        DONE    = 3'd3,
        TIMEOUT = 3'd4
    } seq_state_e;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_FIB  = 3'd1;
    localparam logic [2:0] SEL_SORT = 3'd2;
    localparam logic [2:0] SEL_SAVE = 3'd3;
    localparam logic [2:0] SEL_LOAD = 3'd4;

    // edges = {load, save, sort, fib}; lowest bit wins when several rise together
    function automatic logic [2:0] launch_code(input logic [3:0] edges);
        logic [2:0] code;
        if (edges[0]) begin
            code = SEL_FIB;
        end else if (edges[1]) begin
            code = SEL_SORT;
        end else if (edges[2]) begin
            code = SEL_SAVE;
        end else if (edges[3]) begin
            code = SEL_LOAD;
        end else begin
            code = SEL_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/program_sequencer_halt_detect.sv
// Detects the branch-to-self halt idiom: the pc has stayed put for HALT_CYCLES samples.
// Owns the registered pc copy and the saturating stable counter.
module halt_detect #(
    parameter int PC_W        = 32,
    parameter int HALT_CYCLES = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clr,
    input  logic [PC_W-1:0] pc,
    output logic            halted
);

    localparam int              CNT_W   = $clog2(HALT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALT_CYCLES - 1);

    logic [PC_W-1:0]  pc_q_r;
    logic [CNT_W-1:0] stable_cnt_r;
    logic             same_s;

    assign same_s = (pc == pc_q_r);

    // pc history and count of consecutive unchanged samples
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q_r       <= {PC_W{1'b0}};
            stable_cnt_r <= {CNT_W{1'b0}};
        end else begin
            pc_q_r <= pc;
            if (clr) begin
                stable_cnt_r <= {CNT_W{1'b0}};
            end else if (!same_s) begin
                stable_cnt_r <= {CNT_W{1'b0}};
            end else if (stable_cnt_r != CNT_MAX) begin
                stable_cnt_r <= stable_cnt_r + CNT_W'(1);
            end else begin
                stable_cnt_r <= stable_cnt_r;
            end
        end
    end

    assign halted = !clr && same_s && (stable_cnt_r == CNT_MAX);

endmodule

// File: rtl/program_sequencer.sv
// Launch controller between the debounced buttons and the RISC core: hold-in-reset load window,
// halt detection, result capture and runaway timeout. Optional: PROGRAM_SEQUENCER_CYCLE_COUNT_EN.
module program_sequencer
    import program_seq_pkg::*;
#(
    parameter int SEL_W          = 32,
    parameter int PC_W           = 32,
    parameter int HOLD_CYCLES    = 4,
    parameter int HALT_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fib_req,
    input  logic             sort_req,
    input  logic             save_req,
    input  logic             load_req,
    input  logic [PC_W-1:0]  pc,
    input  logic [31:0]      reg_data,
    output logic             cpu_reset,
    output logic [SEL_W-1:0] program_selector,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [31:0]      result
`ifdef PROGRAM_SEQUENCER_CYCLE_COUNT_EN
    ,
    output logic [31:0]      cycle_count
`endif
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam int RUN_W  = $clog2(TIMEOUT_CYCLES);

    seq_state_e        state_r;
    seq_state_e        state_nxt_s;
    logic [3:0]        req_s;
    logic [3:0]        req_q_r;
    logic [3:0]        edge_s;
    logic              armed_r;
    logic              launch_ok_s;
    logic              load_entry_s;
    logic [2:0]        code_r;
    logic [2:0]        code_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [RUN_W-1:0]  run_cnt_r;
    logic              hold_last_s;
    logic              run_last_s;
    logic              halted_s;

    logic              cpu_reset_r;
    logic [SEL_W-1:0]  sel_r;
    logic              busy_r;
    logic              done_r;
    logic              timeout_r;
    logic [31:0]       result_r;
    logic              cpu_reset_nxt_s;
    logic [SEL_W-1:0]  sel_nxt_s;
    logic              busy_nxt_s;
    logic              done_nxt_s;
    logic              timeout_nxt_s;
    logic [31:0]       result_nxt_s;

    // armed_r masks the first cycle after reset so a button held through reset cannot launch
    assign req_s        = {load_req, save_req, sort_req, fib_req};
    assign edge_s       = armed_r ? (req_s & ~req_q_r) : 4'b0000;
    assign launch_ok_s  = ((state_r == IDLE) || (state_r == DONE) || (state_r == TIMEOUT)) &&
                          (edge_s != 4'b0000);
    assign hold_last_s  = (hold_cnt_r == HOLD_W'(HOLD_CYCLES - 1));
    assign run_last_s   = (run_cnt_r == RUN_W'(TIMEOUT_CYCLES - 1));
    assign load_entry_s = (state_nxt_s == LOAD) && (state_r != LOAD);

    halt_detect #(
        .PC_W        (PC_W),
        .HALT_CYCLES (HALT_CYCLES)
    ) u_halt_detect (
        .clock  (clock),
        .reset  (reset),
        .clr    (state_r != RUN),
        .pc     (pc),
        .halted (halted_s)
    );

    // Next-state logic; halt beats timeout when both fire together
    always_comb begin
        state_nxt_s = state_r;
        code_nxt_s  = code_r;
        case (state_r)
            IDLE, DONE, TIMEOUT: begin
                if (launch_ok_s) begin
                    state_nxt_s = LOAD;
                    code_nxt_s  = launch_code(edge_s);
                end else begin
                    state_nxt_s = state_r;
                end
            end
            LOAD: begin
                if (hold_last_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            RUN: begin
                if (halted_s) begin
                    state_nxt_s = DONE;
                end else if (run_last_s) begin
                    state_nxt_s = TIMEOUT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output values for the state being entered, so outputs are registered yet aligned with state
    always_comb begin
        cpu_reset_nxt_s = 1'b1;
        sel_nxt_s       = {SEL_W{1'b0}};
        busy_nxt_s      = 1'b0;
        done_nxt_s      = 1'b0;
        timeout_nxt_s   = 1'b0;
        case (state_nxt_s)
            IDLE: begin
                cpu_reset_nxt_s = 1'b1;
            end
            LOAD: begin
                sel_nxt_s  = SEL_W'(code_nxt_s);
                busy_nxt_s = 1'b1;
            end
            RUN: begin
                cpu_reset_nxt_s = 1'b0;
                busy_nxt_s      = 1'b1;
            end
            DONE: begin
                cpu_reset_nxt_s = 1'b0;
                done_nxt_s      = 1'b1;
            end
            TIMEOUT: begin
                timeout_nxt_s = 1'b1;
            end
            default: begin
                cpu_reset_nxt_s = 1'b1;
            end
        endcase
    end

    // Result: cleared on launch and on timeout, captured from the core on halt
    always_comb begin
        if (load_entry_s) begin
            result_nxt_s = 32'd0;
        end else if ((state_r == RUN) && (state_nxt_s == DONE)) begin
            result_nxt_s = reg_data;
        end else if (state_nxt_s == TIMEOUT) begin
            result_nxt_s = 32'd0;
        end else begin
            result_nxt_s = result_r;
        end
    end

    // State, edge history and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            req_q_r     <= 4'b0000;
            armed_r     <= 1'b0;
            code_r      <= SEL_NONE;
            cpu_reset_r <= 1'b1;
            sel_r       <= {SEL_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            result_r    <= 32'd0;
        end else begin
            state_r     <= state_nxt_s;
            req_q_r     <= req_s;
            armed_r     <= 1'b1;
            code_r      <= code_nxt_s;
            cpu_reset_r <= cpu_reset_nxt_s;
            sel_r       <= sel_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            timeout_r   <= timeout_nxt_s;
            result_r    <= result_nxt_s;
        end
    end

    // Load window and run-length counters; both idle at zero outside their state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
            run_cnt_r  <= {RUN_W{1'b0}};
        end else begin
            if (state_r == LOAD) begin
                hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            end else begin
                hold_cnt_r <= {HOLD_W{1'b0}};
            end
            if ((state_r == RUN) && !run_last_s) begin
                run_cnt_r <= run_cnt_r + RUN_W'(1);
            end else if (state_r == RUN) begin
                run_cnt_r <= run_cnt_r;
            end else begin
                run_cnt_r <= {RUN_W{1'b0}};
            end
        end
    end

    assign cpu_reset        = cpu_reset_r;
    assign program_selector = sel_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign timeout          = timeout_r;
    assign result           = result_r;

`ifdef PROGRAM_SEQUENCER_CYCLE_COUNT_EN
    logic [31:0] cycle_cnt_r;

    // RUN-length counter, frozen once the program leaves RUN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt_r <= 32'd0;
        end else if (load_entry_s) begin
            cycle_cnt_r <= 32'd0;
        end else if ((state_r == RUN) && (cycle_cnt_r != 32'hFFFF_FFFF)) begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
        end else begin
            cycle_cnt_r <= cycle_cnt_r;
        end
    end

    assign cycle_count = cycle_cnt_r;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: a per-cycle vector table with a scoreboard queue,
// plus a hand-written asynchronous reset check in the middle of RUN.
module tb_program_sequencer;

    localparam int HOLD = 4;
    localparam int HALT = 8;
    localparam int TMO  = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fib_req = 1'b0, sort_req = 1'b0, save_req = 1'b0, load_req = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] reg_data = 32'd0;
    logic        cpu_reset, busy, done, timeout;
    logic [31:0] program_selector, result;
`ifdef PROGRAM_SEQUENCER_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif

    program_sequencer #(
        .SEL_W(32), .PC_W(32), .HOLD_CYCLES(HOLD), .HALT_CYCLES(HALT), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .fib_req(fib_req), .sort_req(sort_req), .save_req(save_req), .load_req(load_req),
        .pc(pc), .reg_data(reg_data),
        .cpu_reset(cpu_reset), .program_selector(program_selector),
        .busy(busy), .done(done), .timeout(timeout), .result(result)
`ifdef PROGRAM_SEQUENCER_CYCLE_COUNT_EN
        , .cycle_count(cycle_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        cpu_reset;
        logic [31:0] sel;
        logic        busy;
        logic        done;
        logic        timeout;
        logic [31:0] result;
        logic [31:0] cyc;
    } out_t;

    typedef struct packed {
        logic [3:0]  req;   // {load, save, sort, fib}
        logic [31:0] pc;
        logic [31:0] rd;
        out_t        exp;
    } vec_t;

    typedef enum int {K_IDLE, K_LOAD, K_RUN, K_DONE, K_TO} kind_e;

    vec_t vecs[$];
    out_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   vec_no = 0;
    int   cyc_m = 0;
    bit   prev_run_m = 1'b0;

    function automatic out_t mk_out(kind_e k, logic [31:0] code, logic [31:0] res, int cyc);
        out_t o;
        o.cpu_reset = !((k == K_RUN) || (k == K_DONE));
        o.sel       = (k == K_LOAD) ? code : 32'd0;
        o.busy      = (k == K_LOAD) || (k == K_RUN);
        o.done      = (k == K_DONE);
        o.timeout   = (k == K_TO);
        o.result    = res;
`ifdef PROGRAM_SEQUENCER_CYCLE_COUNT_EN
        o.cyc       = cyc;
`else
        o.cyc       = 32'd0;
`endif
        return o;
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.cpu_reset = cpu_reset;
        o.sel       = program_selector;
        o.busy      = busy;
        o.done      = done;
        o.timeout   = timeout;
        o.result    = result;
`ifdef PROGRAM_SEQUENCER_CYCLE_COUNT_EN
        o.cyc       = cycle_count;
`else
        o.cyc       = 32'd0;
`endif
        return o;
    endfunction

    // One table row: inputs for a cycle and the outputs expected just after its clock edge
    task automatic add(input logic [3:0] req, input logic [31:0] p, input logic [31:0] rd,
                       input kind_e k, input logic [31:0] code, input logic [31:0] res);
        vec_t v;
        if (k == K_LOAD) cyc_m = 0;
        else if (prev_run_m) cyc_m = cyc_m + 1;
        prev_run_m = (k == K_RUN);
        v.req = req; v.pc = p; v.rd = rd;
        v.exp = mk_out(k, code, res, cyc_m);
        vecs.push_back(v);
    endtask

    task automatic add_launch(input logic [3:0] req, input logic [31:0] p, input logic [31:0] code);
        add(req, p, 32'd0, K_LOAD, code, 32'd0);
        for (int i = 1; i < HOLD; i++) add(4'b0000, 32'd0, 32'd0, K_LOAD, code, 32'd0);
    endtask

    // nsteps distinct pcs, then hold_pc: done appears HALT cycles after pc first repeats
    task automatic add_run_to_halt(input int nsteps, input logic [31:0] base,
                                   input logic [31:0] hold_pc, input logic [31:0] rd);
        for (int i = 0; i < nsteps; i++)
            add(4'b0000, base + 32'(4 * i), 32'h1000 + 32'(i), K_RUN, 32'd0, 32'd0);
        for (int i = 0; i < HALT; i++)
            add(4'b0000, hold_pc, rd, K_RUN, 32'd0, 32'd0);
        add(4'b0000, hold_pc, rd, K_DONE, 32'd0, rd);
    endtask

    task automatic apply_vec(input vec_t v);
        out_t act;
        out_t exp;
        @(negedge clock);
        {load_req, save_req, sort_req, fib_req} = v.req;
        pc = v.pc;
        reg_data = v.rd;
        sb_q.push_back(v.exp);
        @(posedge clock);
        #1;
        exp = sb_q.pop_front();
        act = dut_out();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL vec%0d outputs actual=%h required=%h (cpu_reset,sel,busy,done,timeout,result,cyc)",
                     vec_no, act, exp);
        end
        vec_no++;
    endtask

    task automatic apply_all();
        for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i]);
        vecs.delete();
    endtask

    task automatic check_now(input string name, input out_t exp);
        out_t act;
        act = dut_out();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // fib held through reset and its release must not launch
        fib_req = 1'b1;
        repeat (3) @(negedge clock);
        check_now("reset_state", mk_out(K_IDLE, 32'd0, 32'd0, 0));
        reset = 1'b1;

        for (int i = 0; i < 5; i++) add(4'b0001, 32'd0, 32'd0, K_IDLE, 32'd0, 32'd0);
        for (int i = 0; i < 100; i++) add(4'b0000, 32'd0, 32'd0, K_IDLE, 32'd0, 32'd0);

        // fib launch, then pc steps and parks at 0x40 with reg_data 0x37
        add_launch(4'b0001, 32'd0, 32'd1);
        add_run_to_halt(16, 32'h0, 32'h40, 32'h37);
        for (int i = 0; i < 3; i++) add(4'b0000, 32'h40, 32'h99, K_DONE, 32'd0, 32'h37);

        // fib and sort together from DONE; sort edge in RUN ignored
        add_launch(4'b0011, 32'h40, 32'd1);
        add(4'b0010, 32'h300, 32'h11, K_RUN, 32'd0, 32'd0);
        add(4'b0000, 32'h304, 32'h12, K_RUN, 32'd0, 32'd0);
        add_run_to_halt(2, 32'h400, 32'h500, 32'h55);
        add(4'b0000, 32'h500, 32'h55, K_DONE, 32'd0, 32'h55);

        // sort launch from DONE clears result; pc runs away into TIMEOUT
        add(4'b0010, 32'h500, 32'h55, K_LOAD, 32'd2, 32'd0);
        for (int i = 1; i < HOLD; i++) add(4'b0010, 32'd0, 32'd0, K_LOAD, 32'd2, 32'd0);
        for (int i = 0; i < TMO; i++)
            add(4'b0000, 32'h1000 + 32'(4 * i), 32'(i), K_RUN, 32'd0, 32'd0);
        add(4'b0000, 32'h2000, 32'h77, K_TO, 32'd0, 32'd0);
        add(4'b0000, 32'h2004, 32'h78, K_TO, 32'd0, 32'd0);

        // load launch from TIMEOUT, immediate park, then save beats load
        add_launch(4'b1000, 32'h2008, 32'd4);
        add_run_to_halt(0, 32'h0, 32'h80, 32'h21);
        add_launch(4'b1100, 32'h80, 32'd3);
        for (int i = 0; i < 5; i++)
            add(4'b0000, 32'h600 + 32'(4 * i), 32'd0, K_RUN, 32'd0, 32'd0);
        apply_all();

        // reset between clock edges mid-RUN must act before the next edge
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (cpu_reset !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset cpu_reset=%b busy=%b required cpu_reset=1 busy=0",
                     cpu_reset, busy);
        end
        check_now("async_reset_outputs", mk_out(K_IDLE, 32'd0, 32'd0, 0));
        {load_req, save_req, sort_req, fib_req} = 4'b0000;
        repeat (2) @(negedge clock);
        reset = 1'b1;

        cyc_m = 0;
        prev_run_m = 1'b0;
        for (int i = 0; i < 3; i++) add(4'b0000, 32'd0, 32'd0, K_IDLE, 32'd0, 32'd0);
        add_launch(4'b0001, 32'd0, 32'd1);
        add(4'b0000, 32'h10, 32'd0, K_RUN, 32'd0, 32'd0);
        apply_all();

        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
